// File: rtl/cl_line_capture_if.sv
// ---------------------------------------------------------------------------
// cl_line_capture_if
//   Bundles the video input and the line-commit output of cl_line_capture.
//
//   Signal protocol:
//     iVSYNC / iDE are level qualifiers from the Camera Link deserialiser.
//     iDATA is meaningful only on cycles where iDE=1. There is no back-pressure:
//     every iDE=1 cycle is consumed. oLINE_WE (and oWEA/oWEB) is a single-cycle
//     write strobe with no ready. oMEMIN_0, oPLANES, oCL_ROW and oLINE_CNT are
//     valid and stable for the whole strobe cycle.
//
//   Modports:
//     master : video source / frame-memory side (drives i*, observes o*)
//     slave  : cl_line_capture (observes i*, drives o*)
// ---------------------------------------------------------------------------
interface cl_line_capture_if #(
    parameter int ADDR_WIDTH  = 11,
    parameter int LINE_WIDTH  = 640,
    parameter int PIXEL_WIDTH = 8,
    parameter int TAPS        = 2,
    parameter int PLANES      = 5
) ();
    logic                          iVSYNC;
    logic                          iDE;
    logic [TAPS*PIXEL_WIDTH-1:0]   iDATA;
    logic                          iMEM_SEL;
    logic [PIXEL_WIDTH-1:0]        iTHRESHOLD;
    logic                          oWEA;
    logic                          oWEB;
    logic                          oLINE_WE;
    logic [ADDR_WIDTH-1:0]         oCL_ROW;
    logic [LINE_WIDTH-1:0]         oMEMIN_0;
    logic [PLANES*LINE_WIDTH-1:0]  oPLANES;
    logic [ADDR_WIDTH-1:0]         oLINE_CNT;
    logic                          oOVF;

    modport master (
        output iVSYNC, iDE, iDATA, iMEM_SEL, iTHRESHOLD,
        input  oWEA, oWEB, oLINE_WE, oCL_ROW, oMEMIN_0, oPLANES, oLINE_CNT, oOVF
    );

    modport slave (
        input  iVSYNC, iDE, iDATA, iMEM_SEL, iTHRESHOLD,
        output oWEA, oWEB, oLINE_WE, oCL_ROW, oMEMIN_0, oPLANES, oLINE_CNT, oOVF
    );
endinterface

// File: rtl/cl_line_capture.sv
// ---------------------------------------------------------------------------
// cl_line_capture
//   Camera Link line-capture front end. Thresholds (and optionally bit-plane
//   slices) a TAPS-pixel-per-clock stream into full-line registers and commits
//   each completed line to one of two frame banks with a one-cycle strobe.
//
//   Ports:
//     CCLK        : clock, rising edge
//     RST_N       : asynchronous active-low reset
//     bus         : cl_line_capture_if.slave (video in, line commit out)
//     dbg_state_o : current FSM state (0 IDLE, 1 WAIT_DE, 2 CAPTURE, 3 COMMIT)
//
//   Build option:
//     CL_LINE_CAPTURE_BITPLANE_EN : when defined, the bit-plane line registers
//     are built and drive oPLANES; otherwise oPLANES is tied to zero.
// ---------------------------------------------------------------------------
module cl_line_capture #(
    parameter int ADDR_WIDTH  = 11,
    parameter int LINE_WIDTH  = 640,
    parameter int PIXEL_WIDTH = 8,
    parameter int TAPS        = 2,
    parameter int PLANES      = 5,
    parameter int MAX_ROWS    = 480
) (
    input  logic                 CCLK,
    input  logic                 RST_N,
    cl_line_capture_if.slave     bus,
    output logic [1:0]           dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_DE = 2'd1,
        CAPTURE = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    vs_d_q, de_d_q;
    logic                    bank_q, bank_d;
    logic                    ovf_q, ovf_d;
    logic [ADDR_WIDTH-1:0]   row_q, row_d;
    logic [ADDR_WIDTH-1:0]   col_q, col_d;
    logic [ADDR_WIDTH-1:0]   acc_q, acc_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [LINE_WIDTH-1:0]   line_q, line_d;

    logic                    vs_rise, de_rise;
    logic                    do_clear, do_capture;
    logic [ADDR_WIDTH-1:0]   base_col, base_acc;
    logic                    col_ok;
    logic [TAPS-1:0]         tap_bits;
    logic [ADDR_WIDTH-1:0]   tap_hits;

    assign vs_rise = bus.iVSYNC & ~vs_d_q;
    assign de_rise = bus.iDE & ~de_d_q;

    // Per-tap binarisation (strictly greater than threshold) and hit count.
    always_comb begin
        tap_bits = '0;
        tap_hits = '0;
        for (int t = 0; t < TAPS; t++) begin
            tap_bits[t] = bus.iDATA[t*PIXEL_WIDTH +: PIXEL_WIDTH] > bus.iTHRESHOLD;
            tap_hits    = tap_hits + ADDR_WIDTH'(tap_bits[t]);
        end
    end

    // Next-state and control.
    always_comb begin
        state_d    = state_q;
        bank_d     = bank_q;
        ovf_d      = ovf_q;
        row_d      = row_q;
        col_d      = col_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        do_clear   = 1'b0;
        do_capture = 1'b0;

        if (vs_rise) begin
            // Frame start wins over everything; a line in flight is dropped
            // without a strobe because we never pass through COMMIT.
            state_d = WAIT_DE;
            row_d   = '0;
            col_d   = '0;
            ovf_d   = 1'b0;
            bank_d  = bus.iMEM_SEL;
        end else begin
            case (state_q)
                IDLE: begin
                    // Line arriving after the frame's row budget is spent.
                    if (de_rise && bus.iVSYNC) ovf_d = 1'b1;
                end
                WAIT_DE: begin
                    if (!bus.iVSYNC) begin
                        state_d = IDLE;
                    end else if (de_rise) begin
                        state_d    = CAPTURE;
                        do_clear   = 1'b1;
                        do_capture = 1'b1;
                    end
                end
                CAPTURE: begin
                    if (bus.iDE) begin
                        do_capture = 1'b1;
                    end else begin
                        state_d = COMMIT;
                        cnt_d   = acc_q;
                    end
                end
                COMMIT: begin
                    row_d = row_q + 1'b1;
                    if (int'(row_q) + 1 >= MAX_ROWS) begin
                        state_d = IDLE;
                        if (de_rise && bus.iVSYNC) ovf_d = 1'b1;
                    end else if (de_rise && bus.iVSYNC) begin
                        // Zero-gap blank: line registers still update only at
                        // the end of this cycle, so the strobe window is intact.
                        state_d    = CAPTURE;
                        do_clear   = 1'b1;
                        do_capture = 1'b1;
                    end else begin
                        state_d = WAIT_DE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A new line restarts column and accumulator from zero in the same
        // cycle its first taps are written.
        base_col = do_clear ? '0 : col_q;
        base_acc = do_clear ? '0 : acc_q;
        col_ok   = base_col < ADDR_WIDTH'(LINE_WIDTH);

        if (do_capture) begin
            if (col_ok) begin
                col_d = base_col + ADDR_WIDTH'(TAPS);
                acc_d = base_acc + tap_hits;
            end else begin
                col_d = base_col;
                acc_d = base_acc;
                ovf_d = 1'b1;
            end
        end
    end

    // Binary line register.
    always_comb begin
        line_d = do_clear ? '0 : line_q;
        if (do_capture && col_ok) begin
            line_d[base_col +: TAPS] = tap_bits;
        end
    end

    always_ff @(posedge CCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            // Reset edge detectors high so a level already present when reset
            // releases is not mistaken for a fresh rise.
            vs_d_q  <= 1'b1;
            de_d_q  <= 1'b1;
            bank_q  <= 1'b0;
            ovf_q   <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            vs_d_q  <= bus.iVSYNC;
            de_d_q  <= bus.iDE;
            bank_q  <= bank_d;
            ovf_q   <= ovf_d;
            row_q   <= row_d;
            col_q   <= col_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
        end
    end

`ifdef CL_LINE_CAPTURE_BITPLANE_EN
    logic [PLANES*LINE_WIDTH-1:0] planes_q, planes_d;
    logic [PLANES-1:0][TAPS-1:0]  tap_planes;

    // Plane p carries pixel bit PIXEL_WIDTH-1-p (MSB first).
    always_comb begin
        tap_planes = '0;
        for (int p = 0; p < PLANES; p++) begin
            for (int t = 0; t < TAPS; t++) begin
                tap_planes[p][t] = bus.iDATA[t*PIXEL_WIDTH + PIXEL_WIDTH-1-p];
            end
        end
    end

    always_comb begin
        planes_d = do_clear ? '0 : planes_q;
        if (do_capture && col_ok) begin
            for (int p = 0; p < PLANES; p++) begin
                planes_d[p*LINE_WIDTH + int'(base_col) +: TAPS] = tap_planes[p];
            end
        end
    end

    always_ff @(posedge CCLK or negedge RST_N) begin
        if (!RST_N) begin
            planes_q <= '0;
        end else begin
            planes_q <= planes_d;
        end
    end

    assign bus.oPLANES = planes_q;
`else
    assign bus.oPLANES = {(PLANES*LINE_WIDTH){1'b0}};
`endif

    assign bus.oLINE_WE  = (state_q == COMMIT);
    assign bus.oWEA      = (state_q == COMMIT) & ~bank_q;
    assign bus.oWEB      = (state_q == COMMIT) &  bank_q;
    assign bus.oCL_ROW   = row_q;
    assign bus.oLINE_CNT = cnt_q;
    assign bus.oMEMIN_0  = line_q;
    assign bus.oOVF      = ovf_q;
    assign dbg_state_o   = state_q;

endmodule
